// File: rtl/gen_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gen_stream_pkg
// Purpose  : Shared types and constants for generator-stream blocks.
//            - state_t    : pair_sum controller states
//            - CNT_SINGLE : element count of a single-element result
//            - CNT_PAIR   : element count of a two-element result
//            - SUM_EXT    : guard bits for a three-operand signed add
// Revision : 1.0  initial release
// ============================================================================
package gen_stream_pkg;

    typedef enum logic [1:0] {
        DONE   = 2'd0,
        TAKE_A = 2'd1,
        TAKE_B = 2'd2,
        EMIT   = 2'd3
    } state_t;

    localparam logic [1:0] CNT_SINGLE = 2'd1;
    localparam logic [1:0] CNT_PAIR   = 2'd2;

    // Three WIDTH-bit signed operands always fit in WIDTH+2 bits.
    localparam int SUM_EXT = 2;

endpackage : gen_stream_pkg
`default_nettype wire

// File: rtl/pair_sum_add.sv
`default_nettype none
// ============================================================================
// Module   : pair_sum_add
// Purpose  : Combinational three-operand signed add (a + b + bias).
//            Macro PAIR_SUM_SATURATE_EN: when defined the WIDTH+2-bit sum is
//            clamped to the signed WIDTH-bit range, otherwise it wraps.
// Ports    : i_a, i_b, i_bias  signed WIDTH-bit operands
//            o_sum             signed WIDTH-bit result
// Revision : 1.0  initial release
// ============================================================================
module pair_sum_add
    import gen_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    input  logic signed [WIDTH-1:0] i_bias,
    output logic signed [WIDTH-1:0] o_sum
);

`ifdef PAIR_SUM_SATURATE_EN
    localparam int c_EXT_W = WIDTH + SUM_EXT;

    logic signed [c_EXT_W-1:0] w_ext;
    logic                      w_ovf;

    always_comb begin
        w_ext = $signed({{SUM_EXT{i_a[WIDTH-1]}}, i_a})
              + $signed({{SUM_EXT{i_b[WIDTH-1]}}, i_b})
              + $signed({{SUM_EXT{i_bias[WIDTH-1]}}, i_bias});
        // Result fits only if all bits from the WIDTH-bit sign upward agree.
        w_ovf = ~((&w_ext[c_EXT_W-1:WIDTH-1]) | ~(|w_ext[c_EXT_W-1:WIDTH-1]));
        if (w_ovf) begin
            o_sum = w_ext[c_EXT_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            o_sum = w_ext[WIDTH-1:0];
        end
    end
`else
    // Truncating the extended sum to WIDTH bits equals a plain WIDTH-bit add.
    always_comb begin
        o_sum = i_a + i_b + i_bias;
    end
`endif

endmodule : pair_sum_add
`default_nettype wire

// File: rtl/pair_sum.sv
`default_nettype none
// ============================================================================
// Module   : pair_sum
// Purpose  : Consumes a ready/valid/done element stream and emits pairwise
//            sums (a + b + bias) with an element count (1 or 2) on its own
//            _start/_ready/_valid/_done generator interface.
//            Macro PAIR_SUM_SATURATE_EN selects saturating arithmetic.
// Ports    : _clock, _reset_n (async active-low), _start, bias
//            upstream   : in_0, in_valid, in_done -> in_ready
//            downstream : _ready -> _valid, _done, _0 (sum), _1 (count)
// Revision : 1.0  initial release
// ============================================================================
module pair_sum
    import gen_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset_n,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] bias,
    input  logic signed [WIDTH-1:0] in_0,
    input  logic                    in_valid,
    input  logic                    in_done,
    output logic                    in_ready,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [WIDTH-1:0] _0,
    output logic        [1:0]       _1
);

    state_t                  r_state,     w_state_nxt;
    logic signed [WIDTH-1:0] r_a,         w_a_nxt;
    logic signed [WIDTH-1:0] r_bias,      w_bias_nxt;
    logic                    r_done_seen, w_done_seen_nxt;
    logic                    r_valid,     w_valid_nxt;
    logic signed [WIDTH-1:0] r_sum,       w_sum_nxt;
    logic        [1:0]       r_cnt,       w_cnt_nxt;
    logic                    r_done;

    logic                    w_in_xfer;
    logic                    w_load;
    logic signed [WIDTH-1:0] w_op_a;
    logic signed [WIDTH-1:0] w_op_b;
    logic signed [WIDTH-1:0] w_add_sum;

    pair_sum_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_bias (r_bias),
        .o_sum  (w_add_sum)
    );

    assign in_ready  = (r_state == TAKE_A) || (r_state == TAKE_B);
    assign w_in_xfer = in_ready && in_valid;

    assign _valid = r_valid;
    assign _done  = r_done;
    assign _0     = r_sum;
    assign _1     = r_cnt;

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            r_state     <= DONE;
            r_a         <= '0;
            r_bias      <= '0;
            r_done_seen <= 1'b0;
            r_valid     <= 1'b0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_bias      <= w_bias_nxt;
            r_done_seen <= w_done_seen_nxt;
            r_valid     <= w_valid_nxt;
            r_sum       <= w_sum_nxt;
            r_cnt       <= w_cnt_nxt;
            // Registered so _done stays low through reset and rises one
            // clock after release.
            r_done      <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_bias_nxt      = r_bias;
        w_done_seen_nxt = r_done_seen;
        w_valid_nxt     = r_valid;
        w_cnt_nxt       = r_cnt;
        w_load          = 1'b0;
        w_op_a          = in_0;
        w_op_b          = '0;

        if (_start) begin
            // Restart discards any half-built pair and any unsent result.
            w_bias_nxt      = bias;
            w_done_seen_nxt = 1'b0;
            w_valid_nxt     = 1'b0;
            w_state_nxt     = TAKE_A;
        end else begin
            case (r_state)
                TAKE_A: begin
                    if (w_in_xfer) begin
                        w_a_nxt = in_0;
                        if (in_done) begin
                            // Last element arrived alone: emit it as a single.
                            w_op_a          = in_0;
                            w_load          = 1'b1;
                            w_cnt_nxt       = CNT_SINGLE;
                            w_valid_nxt     = 1'b1;
                            w_done_seen_nxt = 1'b1;
                            w_state_nxt     = EMIT;
                        end else begin
                            w_state_nxt = TAKE_B;
                        end
                    end else if (in_done) begin
                        w_state_nxt = DONE;
                    end
                end
                TAKE_B: begin
                    if (w_in_xfer) begin
                        w_op_a          = r_a;
                        w_op_b          = in_0;
                        w_load          = 1'b1;
                        w_cnt_nxt       = CNT_PAIR;
                        w_valid_nxt     = 1'b1;
                        w_done_seen_nxt = in_done;
                        w_state_nxt     = EMIT;
                    end else if (in_done) begin
                        // Odd tail: flush the held element as a single.
                        w_op_a          = r_a;
                        w_load          = 1'b1;
                        w_cnt_nxt       = CNT_SINGLE;
                        w_valid_nxt     = 1'b1;
                        w_done_seen_nxt = 1'b1;
                        w_state_nxt     = EMIT;
                    end
                end
                EMIT: begin
                    if (r_valid && _ready) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = r_done_seen ? DONE : TAKE_A;
                    end
                end
                default: begin
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign w_sum_nxt = w_load ? w_add_sum : r_sum;

endmodule : pair_sum
`default_nettype wire

// File: tb/tb_pair_sum.sv
`default_nettype none
// ============================================================================
// Module   : tb_pair_sum
// Purpose  : Directed self-checking bench for pair_sum with a result
//            scoreboard (expected results queued as stimulus is driven).
// Revision : 1.0  initial release
// ============================================================================
module tb_pair_sum;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [1:0]       cnt;
    } exp_t;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] bias;
    logic [WIDTH-1:0] in_0;
    logic             in_valid;
    logic             in_done;
    logic             in_ready;
    logic             ready;
    logic             valid;
    logic             done;
    logic [WIDTH-1:0] out_0;
    logic [1:0]       out_1;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    logic [WIDTH-1:0] cur_bias;

    pair_sum #(
        .WIDTH (WIDTH)
    ) dut (
        ._clock   (clock),
        ._reset_n (reset_n),
        ._start   (start),
        .bias     (bias),
        .in_0     (in_0),
        .in_valid (in_valid),
        .in_done  (in_done),
        .in_ready (in_ready),
        ._ready   (ready),
        ._valid   (valid),
        ._done    (done),
        ._0       (out_0),
        ._1       (out_1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
        logic signed [WIDTH+1:0] s;
        s = $signed({{2{a[WIDTH-1]}}, a}) + $signed({{2{b[WIDTH-1]}}, b})
          + $signed({{2{c[WIDTH-1]}}, c});
`ifdef PAIR_SUM_SATURATE_EN
        if (s > $signed(34'h0_7FFF_FFFF)) return 32'h7FFF_FFFF;
        if (s < $signed(34'h3_8000_0000)) return 32'h8000_0000;
`endif
        return s[WIDTH-1:0];
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [1:0] cnt);
        exp_t e;
        e.sum = model(a, b, cur_bias);
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [WIDTH-1:0] b);
        start    = 1'b1;
        bias     = b;
        cur_bias = b;
        @(negedge clock);
        start    = 1'b0;
    endtask

    // Offer one element; returns at the negedge after it was accepted.
    task automatic send(input logic [WIDTH-1:0] v, input logic d);
        int n = 0;
        in_valid = 1'b1;
        in_0     = v;
        in_done  = d;
        while (in_ready !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (n >= 30) chk("send_timeout", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        in_done  = 1'b0;
    endtask

    task automatic send_done();
        in_done = 1'b1;
        @(negedge clock);
        in_done = 1'b0;
    endtask

    // Wait for a result, compare with the scoreboard, stall, then accept it.
    task automatic pop_check(input string tag, input int stall);
        int   n = 0;
        exp_t e;
        logic [WIDTH-1:0] s0;
        logic [1:0]       s1;
        while (valid !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (n >= 30) chk({tag, "_valid_timeout"}, 64'(valid), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_sum"}, 64'(out_0), 64'(e.sum));
        chk({tag, "_cnt"}, 64'(out_1), 64'(e.cnt));
        chk({tag, "_in_ready_emit"}, 64'(in_ready), 64'd0);
        s0 = out_0;
        s1 = out_1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk({tag, "_stall_valid"}, 64'(valid), 64'd1);
            chk({tag, "_stall_sum"}, 64'(out_0), 64'(s0));
            chk({tag, "_stall_cnt"}, 64'(out_1), 64'(s1));
            chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
        end
        ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(valid), 64'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        bias     = '0;
        cur_bias = '0;
        in_0     = '0;
        in_valid = 1'b0;
        in_done  = 1'b0;
        ready    = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out0", 64'(out_0), 64'd0);
        chk("rst_out1", 64'(out_1), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_done_rise", 64'(done), 64'd1);

        // Duplicated range
        do_start(32'd0);
        chk("dup_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            send(32'(2 * k), 1'b0);
            send(32'(2 * k), 1'b0);
            push_exp(32'(2 * k), 32'(2 * k), 2'd2);
            pop_check("dup", 0);
        end
        send_done();
        chk("dup_done", 64'(done), 64'd1);
        chk("dup_done_in_ready", 64'(in_ready), 64'd0);

        // Odd tail
        do_start(32'd1);
        send(32'd5, 1'b0);
        send(32'd7, 1'b0);
        push_exp(32'd5, 32'd7, 2'd2);
        pop_check("odd_pair", 0);
        send(32'd9, 1'b0);
        send_done();
        push_exp(32'd9, 32'd0, 2'd1);
        pop_check("odd_tail", 0);
        chk("odd_done", 64'(done), 64'd1);

        // Valid together with done
        do_start(32'd0);
        send(32'd3, 1'b1);
        push_exp(32'd3, 32'd0, 2'd1);
        pop_check("vd", 0);
        chk("vd_done", 64'(done), 64'd1);

        // Backpressure
        do_start(32'd0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        push_exp(32'd1, 32'd2, 2'd2);
        pop_check("bp1", 5);
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        push_exp(32'd3, 32'd4, 2'd2);
        pop_check("bp2", 5);

        // Overflow
        do_start(32'd0);
        send(32'h7FFF_FFFF, 1'b0);
        send(32'd1, 1'b0);
        push_exp(32'h7FFF_FFFF, 32'd1, 2'd2);
        pop_check("ovf", 0);

        // Negative operands with negative bias
        do_start(32'hFFFF_FFF6);
        send(32'hFFFF_FFFD, 1'b0);
        send(32'd4, 1'b0);
        push_exp(32'hFFFF_FFFD, 32'd4, 2'd2);
        pop_check("neg", 0);

        // Async reset mid-TAKE_B
        send(32'd11, 1'b0);
        chk("arst_pre_in_ready", 64'(in_ready), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_valid", 64'(valid), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_out0", 64'(out_0), 64'd0);
        chk("arst_out1", 64'(out_1), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("arst_done_rise", 64'(done), 64'd1);

        // _start reasserted in EMIT
        do_start(32'd0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        chk("restart_pending_valid", 64'(valid), 64'd1);
        do_start(32'd100);
        chk("restart_valid_drop", 64'(valid), 64'd0);
        chk("restart_in_ready", 64'(in_ready), 64'd1);
        send(32'd5, 1'b0);
        send(32'd6, 1'b0);
        push_exp(32'd5, 32'd6, 2'd2);
        pop_check("restart", 0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pair_sum
`default_nettype wire

// File: doc/pair_sum.md
Name: pair_sum

Overview:
- Downstream consumer of the dup_range generator stream.
- Accepts the generator's ready/valid/done output and combines consecutive elements pairwise.
- Emits its own generator stream: each output is (a + b + bias), with an element count.
- Bridges duplicated-value generators into the next arithmetic stage. It presents the same _start/_ready/_valid/_done contract downstream.

Parameters:
- WIDTH, 32: data width of the input element, bias and sum (signed).

Ports:
- _clock  input  1  sole clock, rising edge.
- _reset_n  input  1  asynchronous active-low reset.
- _start  input  1  captures bias and begins consuming; precedence over everything except reset.
- bias  input  WIDTH  signed offset added to every emitted sum; captured on _start.
- in_0  input  WIDTH  upstream element (connects to the generator's _0).
- in_valid  input  1  upstream element valid.
- in_done  input  1  upstream finished.
- in_ready  output  1  this block can take an element.
- _ready  input  1  downstream ready for output.
- _valid  output  1  _0/_1 hold a valid result.
- _done  output  1  high while idle/finished.
- _0  output  WIDTH  signed sum.
- _1  output  2  number of elements in the sum (1 or 2).

Behaviour:
- Reset (async, active-low):
  - state=DONE.
  - in_ready=0, _valid=0, _done=0 (rises to 1 on the first clock after release), _0=0, _1=0.
  - Internal a/bias/done_seen all cleared to 0.
- States: DONE, TAKE_A, TAKE_B, EMIT.
- Upstream transfer: in_ready && in_valid at a posedge.
- Output transfer: _valid && _ready at a posedge.
- _valid, once set, holds with _0/_1 stable until the output transfer.
- _start (any state, including mid-operation):
  - Captures bias, clears done_seen, drops any pending element and any un-transferred output (_valid=0).
  - Goes to TAKE_A with in_ready=1 the next cycle.
- TAKE_A (in_ready=1):
  - On transfer: a<=in_0, go to TAKE_B.
  - If in_done is also high that cycle: set done_seen and go to EMIT with _0=a+bias, _1=1.
  - in_done without a transfer: go to DONE, emitting nothing.
- TAKE_B (in_ready=1):
  - On transfer: _0<=a+in_0+bias, _1<=2, _valid<=1, go to EMIT; done_seen<=in_done.
  - in_done without a transfer: _0<=a+bias, _1<=1, _valid<=1, done_seen<=1, go to EMIT.
- EMIT (in_ready=0):
  - Wait for the output transfer.
  - Then go to DONE if done_seen, else TAKE_A.
  - An output transfer and a new upstream transfer never occur in the same cycle.
- DONE: _done=1 each cycle, in_ready=0, _valid=0 after any final transfer.
- Latency: second element accepted at cycle t → _valid high at t+1. Minimum 3 cycles per pair (A, B, EMIT).
- Arithmetic:
  - Signed WIDTH-bit two's-complement.
  - Intermediate sum is WIDTH+2 bits, truncated to WIDTH (wrap) unless the optional feature is enabled.
- Simultaneous in_valid and in_done: the element is consumed first, then done is honoured (rules above).
- No element is ever lost except on _start or reset.

Optional Feature:
- Macro PAIR_SUM_SATURATE_EN.
- Defined: the WIDTH+2-bit sum is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before _0 is registered.
- Undefined: plain truncation (wrap-around).
- Counts, handshake and latency are identical in both builds.

Decomposition:
- Package gen_stream_pkg holds:
  - the state enum (DONE, TAKE_A, TAKE_B, EMIT);
  - the count constants CNT_SINGLE=1 and CNT_PAIR=2;
  - the SUM_EXT=2 guard-bit constant.
- One natural sub-module: pair_sum_add.
  - Combinational three-operand add with optional saturation under PAIR_SUM_SATURATE_EN.
  - Keeps the FSM free of width/clamp logic.

Test Plan:
- Duplicated range: bias=0, upstream stream 0,0,2,2,4,4,6,6,8,8 then in_done, _ready=1 → outputs (0,2),(4,2),(8,2),(12,2),(16,2), then _done high; in_ready never high during EMIT.
- Odd tail: bias=1, stream 5,7,9 then in_done one cycle after 9 → (13,2),(10,1), then DONE.
- Valid with done: bias=0, stream 3 with in_valid and in_done asserted in the same cycle → single output (3,1), then DONE.
- Backpressure: stream 1,2,3,4 with _ready low for 5 cycles on each output → _0/_1/_valid held stable; results (3,2),(7,2); in_ready low throughout the stall.
- Overflow: bias=0, pair 0x7FFFFFFF,1 → 0x80000000 without the macro, 0x7FFFFFFF with PAIR_SUM_SATURATE_EN.
- Disruption:
  - _reset_n pulsed low mid-TAKE_B → outputs are at reset values immediately (async); _done=1 after release.
  - _start reasserted in EMIT → pending output discarded; the next pair sums with the new bias.
